pdm_adc: RTL and testbench
==========================

Name: pdm_adc

Overview:
- Receive side of the 1-bit delta-sigma path: drives the clock of an on-board PDM microphone and samples its 1-bit data stream.
- Decimates the bitstream with an N-stage CIC filter into signed PCM samples, each marked by a one-cycle valid strobe.
- Sits between the PDM mic pins and the audio capture/mixing logic, running in the main system clock domain.

Parameters:
- DATA_WIDTH, 16, output sample width; must satisfy DATA_WIDTH <= G.
- CLK_DIV, 50, clk_i cycles per pdm_clk_o half-period; must satisfy 2*CLK_DIV >= CIC_ORDER+2.
- DECIM_LOG2, 6, log2 of the decimation ratio R (R = 64 bits per sample).
- CIC_ORDER, 3, number of integrator and comb stages N; valid range 1..4.
- Derived: G = CIC_ORDER*DECIM_LOG2 (18 by default); internal width W = G+1.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- enable_i  in  1  run enable; low holds the block idle.
- pdm_data_i  in  1  microphone data pin (asynchronous to clk_i).
- pdm_clk_o  out  1  microphone clock.
- sample_o  out  DATA_WIDTH  signed PCM sample.
- valid_o  out  1  one-cycle strobe; sample_o is valid while it is high.

Behaviour:
- Reset values: pdm_clk_o=0, sample_o=0, valid_o=0. All counters, integrators, combs, synchronizer flops and the warmup counter are cleared.
- Reset is asserted asynchronously and released synchronously.
- Clock divider:
  - counter runs 0..CLK_DIV-1 while enable_i=1;
  - at CLK_DIV-1 the counter wraps and pdm_clk_o toggles.
- Data capture:
  - pdm_data_i passes through a 2-flop synchronizer;
  - bit_tick fires in the clk_i cycle where pdm_clk_o goes 0->1;
  - on bit_tick the synchronized bit (0 or 1) is added into integrator 1.
- Integrators:
  - N cascaded W-bit accumulators, all updated on bit_tick only;
  - arithmetic wraps modulo 2^W (no saturation; CIC arithmetic relies on the wrap).
- Decimation:
  - a DECIM_LOG2-bit bit counter increments on each bit_tick;
  - dec_tick fires on the bit_tick where the counter wraps from R-1 to 0, i.e. every R bits.
- Comb pipeline:
  - on dec_tick the last integrator output is latched;
  - N comb stages follow, one stage per clk_i cycle: y = x - x_delayed, with the delayed value updated once per dec_tick, all modulo 2^W;
  - the result is then registered into the output stage.
  - valid_o asserts exactly N+1 clk_i cycles after the dec_tick cycle.
- Output conversion:
  - c = comb result interpreted as unsigned, range 0..2^G;
  - s = c - 2^(G-1);
  - saturate s to [-2^(G-1), 2^(G-1)-1];
  - sample_o = s arithmetically shifted right by G-DATA_WIDTH.
  - sample_o holds its value between strobes.
- Warmup:
  - the first N dec_ticks after reset or after enable_i rises produce no valid_o (CIC transient);
  - the first valid_o follows the (N+1)-th dec_tick.
- enable_i low:
  - synchronous effect on the next clk_i edge: pdm_clk_o=0, divider and bit counter cleared, integrators/combs/warmup counter cleared;
  - any valid_o still in the comb pipeline is cancelled;
  - sample_o keeps its last value.
- enable_i re-asserted: the divider starts from 0, so the first pdm_clk_o rise occurs CLK_DIV cycles later.
- Reset mid-sample: all state is dropped immediately; the partial sample is never emitted.
- Rate: for clk_i = 100 MHz with default parameters, pdm_clk_o = 1 MHz and valid_o strobes every 6400 clk_i cycles (15.625 kHz).

Test Plan:
- Reset, enable_i=1, pdm_data_i held 1 -> pdm_clk_o period = 100 clk_i cycles; first valid_o follows the 4th dec_tick; steady-state sample_o = 0x7FFF (saturated).
- pdm_data_i held 0 -> steady-state sample_o = 0x8000 (-32768).
- pdm_data_i alternating 1,0 per bit_tick -> steady-state sample_o = 0x0000; valid_o period exactly 6400 cycles, each strobe exactly 1 cycle wide.
- Pattern 1,1,1,0 repeating (75% density) -> steady-state sample_o = 0x4000; valid_o exactly 4 clk_i cycles after each dec_tick.
- enable_i dropped mid-sample, re-asserted 500 cycles later -> pdm_clk_o=0 while disabled; no valid_o during the 3 warmup dec_ticks after re-enable; correct values afterwards.
- rst_n_i pulsed low asynchronously between clock edges during a comb pipeline cycle -> outputs go to 0 immediately; no stray valid_o; normal restart after release.

Source files
------------

// File: rtl/pdm_adc.sv
// PDM microphone receiver: drives the mic clock, samples its bitstream and
// decimates it through an N-stage CIC filter into signed PCM samples.
module pdm_adc #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 50,
  parameter int DECIM_LOG2 = 6,
  parameter int CIC_ORDER  = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         enable_i,
  input  logic                         pdm_data_i,
  output logic                         pdm_clk_o,
  output logic signed [DATA_WIDTH-1:0] sample_o,
  output logic                         valid_o
);

  localparam int G     = CIC_ORDER * DECIM_LOG2;
  localparam int W     = G + 1;
  localparam int SHIFT = G - DATA_WIDTH;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       WARM_N   = 3'(CIC_ORDER);
  localparam logic [W:0]       HALF     = (W+1)'(1) << (G - 1);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [DIV_W-1:0]      div_cnt;
  logic                  div_wrap;
  logic                  bit_tick;
  logic                  dec_tick;
  logic [1:0]            pdm_sync;
  logic [DECIM_LOG2-1:0] bit_cnt;
  logic [2:0]            warm_cnt;
  logic                  emit_q;
  logic [W-1:0]          integ  [CIC_ORDER];
  logic [W-1:0]          comb_x [CIC_ORDER];
  logic [W-1:0]          comb_d [CIC_ORDER];
  logic [CIC_ORDER-1:0]  stg;
  logic [W:0]            c_ext;
  logic [W:0]            s_full;
  logic signed [G-1:0]   s_sat;
  logic [DATA_WIDTH-1:0] sample_next;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign div_wrap = (div_cnt == DIV_LAST);
  assign bit_tick = enable_i & div_wrap & ~pdm_clk_o;
  assign dec_tick = bit_tick & (bit_cnt == '1);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      pdm_clk_o <= 1'b0;
    end else if (!enable_i) begin
      div_cnt   <= '0;
      pdm_clk_o <= 1'b0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      pdm_clk_o <= ~pdm_clk_o;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) pdm_sync <= '0;
    else        pdm_sync <= {pdm_sync[0], pdm_data_i};
  end

  // Integrators wrap modulo 2^W; the combs cancel the wrap exactly.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      warm_cnt <= '0;
      emit_q   <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
    end else if (!enable_i) begin
      bit_cnt  <= '0;
      warm_cnt <= '0;
      emit_q   <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
    end else if (bit_tick) begin
      bit_cnt  <= bit_cnt + 1'b1;
      integ[0] <= integ[0] + {{(W-1){1'b0}}, pdm_sync[1]};
      for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
      if (dec_tick) begin
        emit_q <= (warm_cnt == WARM_N);
        if (warm_cnt != WARM_N) warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  // Comb stage 1 runs on dec_tick itself; stage k runs k-1 cycles later.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stg      <= '0;
      valid_o  <= 1'b0;
      sample_o <= '0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        comb_x[k] <= '0;
        comb_d[k] <= '0;
      end
    end else if (!enable_i) begin
      stg     <= '0;
      valid_o <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) begin
        comb_x[k] <= '0;
        comb_d[k] <= '0;
      end
    end else begin
      stg[0] <= dec_tick;
      for (int k = 1; k < CIC_ORDER; k++) stg[k] <= stg[k-1];
      if (dec_tick) begin
        comb_d[0] <= integ[CIC_ORDER-1];
        comb_x[0] <= integ[CIC_ORDER-1] - comb_d[0];
      end
      for (int k = 1; k < CIC_ORDER; k++) begin
        if (stg[k-1]) begin
          comb_x[k] <= comb_x[k-1] - comb_d[k];
          comb_d[k] <= comb_x[k-1];
        end
      end
      valid_o <= stg[CIC_ORDER-1] & emit_q;
      if (stg[CIC_ORDER-1] & emit_q) sample_o <= sample_next;
    end
  end

  // Full-scale density maps to 2^G, one past the signed maximum, hence the clamp.
  always_comb begin
    c_ext  = {1'b0, comb_x[CIC_ORDER-1]};
    s_full = c_ext - HALF;
    if (s_full[W:G-1] == '0 || s_full[W:G-1] == '1)
      s_sat = s_full[G-1:0];
    else if (s_full[W])
      s_sat = {1'b1, {(G-1){1'b0}}};
    else
      s_sat = {1'b0, {(G-1){1'b1}}};
    sample_next = DATA_WIDTH'(s_sat >>> SHIFT);
  end

endmodule

// File: tb/tb_pdm_adc.sv
// Scoreboard bench for pdm_adc: expected samples are queued when the bench
// sees a decimation point on pdm_clk_o and compared when valid_o strobes.
module tb_pdm_adc;

  localparam int CLK_DIV = 5;
  localparam int DL      = 6;
  localparam int N       = 3;
  localparam int DW      = 16;
  localparam int G       = N * DL;
  localparam int R       = 1 << DL;
  localparam int SAMP_CYC = R * 2 * CLK_DIV;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i;
  logic                 enable_i;
  logic                 pdm_data_i;
  logic                 pdm_clk_o;
  logic signed [DW-1:0] sample_o;
  logic                 valid_o;

  pdm_adc #(
    .DATA_WIDTH(DW),
    .CLK_DIV(CLK_DIV),
    .DECIM_LOG2(DL),
    .CIC_ORDER(N)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .enable_i(enable_i),
    .pdm_data_i(pdm_data_i),
    .pdm_clk_o(pdm_clk_o),
    .sample_o(sample_o),
    .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          at;
    logic [DW-1:0] smp;
  } exp_t;

  exp_t          sb_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            bits, decs, n_match;
  int            last_rise, prev_rise, last_vcyc, prev_vcyc;
  logic          prev_clk;
  logic [3:0]    pat;
  int            plen;
  logic [DW-1:0] cur_exp;

  function automatic logic [DW-1:0] exp_sample(input int ones, input int len);
    longint c, s, lim;
    lim = longint'(1) << (G - 1);
    c = (longint'(ones) * (longint'(1) << G)) / len;
    s = c - lim;
    if (s > lim - 1) s = lim - 1;
    if (s < -lim) s = -lim;
    s = s >>> (G - DW);
    return s[DW-1:0];
  endfunction

  task automatic model_start(input logic [3:0] p, input int len, input int ones);
    pat = p;
    plen = len;
    cur_exp = exp_sample(ones, len);
    bits = 0;
    decs = 0;
    n_match = 0;
    prev_clk = 1'b0;
    sb_q.delete();
    pdm_data_i = pat[0];
  endtask

  // One clock of the scoreboard: expire, match strobes, track pdm_clk_o rises.
  task automatic step();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (sb_q.size() > 0 && sb_q[0].at < cyc) begin
      e = sb_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_valid: no strobe seen, required one at cycle %0d", e.at);
    end
    if (valid_o === 1'b1) begin
      total++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL stray_valid: strobe at cycle %0d, required none", cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.at != cyc || sample_o !== e.smp) begin
          bad++;
          $display("FAIL sample: cycle %0d value %h, required cycle %0d value %h",
                   cyc, sample_o, e.at, e.smp);
        end else begin
          n_match++;
        end
      end
    end
    if (enable_i && rst_n_i && pdm_clk_o === 1'b1 && prev_clk === 1'b0) begin
      bits++;
      prev_rise = last_rise;
      last_rise = cyc;
      if (bits % R == 0) begin
        decs++;
        if (decs > N) begin
          e.at = cyc + N;
          e.smp = cur_exp;
          sb_q.push_back(e);
        end
      end
      pdm_data_i = pat[bits % plen];
    end
    prev_clk = pdm_clk_o;
  endtask

  task automatic run_to_decs(input int target);
    int guard;
    guard = (target - decs + 1) * SAMP_CYC + 4 * CLK_DIV;
    while (decs < target && guard > 0) begin
      step();
      guard--;
    end
    repeat (N + 2) step();
  endtask

  task automatic restart(input logic [3:0] p, input int len, input int ones);
    enable_i = 1'b0;
    model_start(p, len, ones);
    step();
    step();
    enable_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    enable_i = 1'b0;
    pdm_data_i = 1'b0;
    repeat (3) @(negedge clk_i);
    total++;
    if (pdm_clk_o !== 1'b0) begin bad++; $display("FAIL reset_pdm_clk: got %b required 0", pdm_clk_o); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    total++;
    if (sample_o !== 16'h0000) begin bad++; $display("FAIL reset_sample: got %h required 0000", sample_o); end
    rst_n_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_ones();
    restart(4'b0001, 1, 1);
    run_to_decs(6);
    total++;
    if (last_rise - prev_rise != 2 * CLK_DIV) begin
      bad++;
      $display("FAIL pdm_clk_period: got %0d required %0d", last_rise - prev_rise, 2 * CLK_DIV);
    end
    total++;
    if (n_match != 3) begin bad++; $display("FAIL ones_count: got %0d strobes required 3", n_match); end
    total++;
    if (sample_o !== 16'h7FFF) begin bad++; $display("FAIL ones_value: got %h required 7fff", sample_o); end
  endtask

  task automatic test_zeros();
    restart(4'b0000, 1, 0);
    run_to_decs(6);
    total++;
    if (n_match != 3) begin bad++; $display("FAIL zeros_count: got %0d strobes required 3", n_match); end
    total++;
    if (sample_o !== 16'h8000) begin bad++; $display("FAIL zeros_value: got %h required 8000", sample_o); end
  endtask

  task automatic test_alternating();
    restart(4'b0001, 2, 1);
    run_to_decs(6);
    total++;
    if (last_vcyc - prev_vcyc != SAMP_CYC) begin
      bad++;
      $display("FAIL valid_period: got %0d required %0d", last_vcyc - prev_vcyc, SAMP_CYC);
    end
    total++;
    if (n_match != 3) begin bad++; $display("FAIL alt_count: got %0d strobes required 3", n_match); end
    total++;
    if (sample_o !== 16'h0000) begin bad++; $display("FAIL alt_value: got %h required 0000", sample_o); end
  endtask

  task automatic test_density75();
    restart(4'b0111, 4, 3);
    run_to_decs(7);
    total++;
    if (n_match != 4) begin bad++; $display("FAIL d75_count: got %0d strobes required 4", n_match); end
    total++;
    if (sample_o !== 16'h4000) begin bad++; $display("FAIL d75_value: got %h required 4000", sample_o); end
  endtask

  task automatic test_enable_toggle();
    int clk_bad, hold_bad, c0, guard;
    restart(4'b0000, 1, 0);
    run_to_decs(5);
    guard = SAMP_CYC;
    while (bits < 5 * R + R / 4 && guard > 0) begin step(); guard--; end
    enable_i = 1'b0;
    model_start(4'b0111, 4, 3);
    clk_bad = 0;
    hold_bad = 0;
    repeat (500) begin
      step();
      if (pdm_clk_o !== 1'b0) clk_bad++;
      if (sample_o !== 16'h8000) hold_bad++;
    end
    total++;
    if (clk_bad != 0) begin bad++; $display("FAIL dis_pdm_clk: %0d cycles high, required 0", clk_bad); end
    total++;
    if (hold_bad != 0) begin bad++; $display("FAIL dis_hold: %0d cycles not 8000, required 0", hold_bad); end
    enable_i = 1'b1;
    c0 = cyc;
    guard = 4 * CLK_DIV;
    while (bits == 0 && guard > 0) begin step(); guard--; end
    total++;
    if (bits != 1 || last_rise - c0 != CLK_DIV) begin
      bad++;
      $display("FAIL first_rise: got %0d cycles required %0d", last_rise - c0, CLK_DIV);
    end
    run_to_decs(5);
    total++;
    if (n_match != 2) begin bad++; $display("FAIL reen_count: got %0d strobes required 2", n_match); end
    total++;
    if (sample_o !== 16'h4000) begin bad++; $display("FAIL reen_value: got %h required 4000", sample_o); end
  endtask

  task automatic test_async_reset();
    int guard;
    restart(4'b0001, 1, 1);
    guard = 6 * SAMP_CYC;
    while (decs < 5 && guard > 0) begin step(); guard--; end
    #2 rst_n_i = 1'b0;
    #1;
    total++;
    if (sample_o !== 16'h0000 || valid_o !== 1'b0 || pdm_clk_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got sample %h valid %b clk %b, required 0000 0 0",
               sample_o, valid_o, pdm_clk_o);
    end
    model_start(4'b0001, 1, 1);
    repeat (8) step();
    rst_n_i = 1'b1;
    run_to_decs(4);
    total++;
    if (n_match != 1) begin bad++; $display("FAIL rst_restart_count: got %0d strobes required 1", n_match); end
    total++;
    if (sample_o !== 16'h7FFF) begin bad++; $display("FAIL rst_restart_value: got %h required 7fff", sample_o); end
  endtask

  initial begin
    pat = 4'b0000;
    plen = 1;
    bits = 0;
    decs = 0;
    n_match = 0;
    last_rise = 0;
    prev_rise = 0;
    last_vcyc = 0;
    prev_vcyc = 0;
    prev_clk = 1'b0;
    cur_exp = '0;
    test_reset();
    test_ones();
    test_zeros();
    test_alternating();
    test_density75();
    test_enable_toggle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
